alu_issue_ctrl: RTL
===================

# alu_issue_ctrl

Upstream issue stage for the 2-operand `alu`. It buffers incoming register-to-register instructions in a small FIFO and owns a small register file. It issues one instruction per cycle to the ALU, with a stall on read-after-write hazards, and writes the ALU's registered result and flags back into the register file. It absorbs the ALU's one-cycle registered latency, so upstream logic sees a plain valid/ready instruction port.

## Interface
- OPCODE_WIDTH, 2, opcode bus is OPCODE_WIDTH+1 bits (matches ALU)
- DATA_WIDTH, 3, data bus is DATA_WIDTH+1 bits (matches ALU)
- FIFO_DEPTH, 4, instruction FIFO entries (power of 2)
- NREGS, 4, register file entries; index width RW = clog2(NREGS)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- in_valid  in  1  instruction offered
- in_ready  out  1  FIFO can accept (= !full)
- in_opcode  in  OPCODE_WIDTH+1  0 add, 1 sub, 2 incr, 3 decr, 4..7 NOP
- in_dst, in_src1, in_src2  in  RW each  register indices
- cfg_we  in  1  direct register write strobe
- cfg_addr  in  RW  register index; cfg_data  in  DATA_WIDTH+1  write value
- alu_opcode  out  OPCODE_WIDTH+1  to ALU OPCODE (registered)
- alu_op1, alu_op2  out  DATA_WIDTH+1  to ALU OP1/OP2 (registered)
- alu_result  in  DATA_WIDTH+1; alu_carry  in  1; alu_zero  in  1  from ALU
- wb_valid  out  1  writeback happening this cycle
- wb_dst  out  RW; wb_data  out  DATA_WIDTH+1  writeback target and value
- flag_c, flag_z  out  1  sticky status from last writeback (registered)
- busy  out  1  FIFO non-empty or op in flight

## Operation
- FIFO holds {opcode, dst, src1, src2}.
- Push on in_valid && in_ready. No fall-through: a pushed entry becomes head at the next edge at the earliest.
- Pipeline tracker: s1 {valid, dst} is set at the issue edge E. s2 is s1 delayed one cycle. ALU outputs are valid while s2.valid (cycle E+1..E+2).
- Issue condition, evaluated each cycle with FIFO non-empty:
  - For opcode 0..3: neither src1 nor src2 equals s1.dst (when s1.valid) or s2.dst (when s2.valid). src2 is checked for all ops, including incr/decr.
  - NOP (opcode ≥4): always issuable.
- On issue of opcode 0..3:
  - Pop the FIFO.
  - Register alu_opcode, alu_op1 = reg[src1], alu_op2 = reg[src2].
  - Set s1 = {1, dst}.
- On issue of a NOP: pop only. alu_* hold their values and s1.valid = 0.
- When not issuing, alu_* hold their last values and s1.valid = 0.
- Writeback: wb_valid = s2.valid, wb_dst = s2.dst, wb_data = alu_result (combinational). At the next edge:
  - reg[s2.dst] <= alu_result
  - flag_c <= alu_carry
  - flag_z <= alu_zero
- cfg write: reg[cfg_addr] <= cfg_data at the edge. If it targets the same register as a writeback at the same edge, the writeback wins. cfg writes are not hazard-checked.
- busy = !empty || s1.valid || s2.valid.

## Timing
- Reset values:
  - FIFO empty, in_ready = 1
  - all registers 0
  - s1/s2 invalid, so wb_valid = 0
  - alu_opcode/op1/op2 = 0
  - flag_c = flag_z = 0, busy = 0
- Reset mid-operation discards FIFO contents and in-flight ops; no writeback follows.
- Latency:
  - issue edge E → ALU samples at E+1 → register file and flags updated at E+2
  - independent ops: one issue per cycle
  - dependent op (source = earlier dst): issues no earlier than E+3 and reads the updated value
- Simultaneous push and pop:
  - when not full, both occur and the count is unchanged
  - when full, in_ready = 0 and no push happens, even if a pop occurs that cycle
- FIFO pointers wrap modulo FIFO_DEPTH. The count saturates logic at 0 (no pop) and FIFO_DEPTH (no push).
- Width rules are the ALU's: DATA_WIDTH+2-bit result, with carry = MSB. This block does no arithmetic beyond FIFO and pointer bookkeeping.

## Test plan
- cfg r1=9, r2=8; push ADD r0=r1+r2 → wb_valid 2 cycles after issue, wb_data=1, flag_c=1, flag_z=0, r0=1.
- cfg r2=5; SUB r3=r2-r2 → wb_data=0, flag_z=1, flag_c=0. Then DECR r3=r3 with r3=0 → wb_data=15, flag_c=1.
- ADD r0=r1+r2 then INCR r1=r0 pushed back-to-back → second issue exactly 3 cycles after the first; r1 = old r0 sum + 1. Independent ops issue on consecutive cycles.
- Hold hazard stall at head, push 5 instructions back-to-back → in_ready=0 after 4 accepted. The 5th is held until a pop, then accepted; order is preserved.
- cfg_we to r0 in the same cycle as writeback to r0 → writeback value retained. NOP opcode 5 → popped, no wb_valid.
- Assert rstn low one cycle after an issue → no wb_valid afterwards, registers 0, in_ready=1, busy=0.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: FIFO-buffered issue stage with RAW stall and register-file writeback for the 2-operand ALU
module alu_issue_ctrl #(
    parameter int OPCODE_WIDTH = 2,
    parameter int DATA_WIDTH   = 3,
    parameter int FIFO_DEPTH   = 4,
    parameter int NREGS        = 4,
    localparam int RW          = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OPCODE_WIDTH:0]   in_opcode,
    input  logic [RW-1:0]           in_dst,
    input  logic [RW-1:0]           in_src1,
    input  logic [RW-1:0]           in_src2,
    input  logic                    cfg_we,
    input  logic [RW-1:0]           cfg_addr,
    input  logic [DATA_WIDTH:0]     cfg_data,
    output logic [OPCODE_WIDTH:0]   alu_opcode,
    output logic [DATA_WIDTH:0]     alu_op1,
    output logic [DATA_WIDTH:0]     alu_op2,
    input  logic [DATA_WIDTH:0]     alu_result,
    input  logic                    alu_carry,
    input  logic                    alu_zero,
    output logic                    wb_valid,
    output logic [RW-1:0]           wb_dst,
    output logic [DATA_WIDTH:0]     wb_data,
    output logic                    flag_c,
    output logic                    flag_z,
    output logic                    busy
);
    localparam int OW = OPCODE_WIDTH + 1;
    localparam int DW = DATA_WIDTH + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = OW + 3 * RW;

    logic [EW-1:0]  fifo [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [PW:0]    count;
    logic [DW-1:0]  regs [NREGS];
    logic           s1_valid, s2_valid;
    logic [RW-1:0]  s1_dst, s2_dst;
    logic [OW-1:0]  head_op;
    logic [RW-1:0]  head_dst, head_src1, head_src2;
    logic           empty, push, head_nop, hazard, issue, issue_alu;

    assign {head_op, head_dst, head_src1, head_src2} = fifo[rd_ptr];
    assign empty     = count == '0;
    assign in_ready  = count != (PW+1)'(FIFO_DEPTH);
    assign push      = in_valid && in_ready;
    assign head_nop  = head_op > OW'(3);
    // src2 is checked for every ALU op, even the single-operand incr/decr
    assign hazard    = (s1_valid && (head_src1 == s1_dst || head_src2 == s1_dst)) ||
                       (s2_valid && (head_src1 == s2_dst || head_src2 == s2_dst));
    assign issue     = !empty && (head_nop || !hazard);
    assign issue_alu = issue && !head_nop;

    assign wb_valid = s2_valid;
    assign wb_dst   = s2_dst;
    assign wb_data  = alu_result;
    assign busy     = !empty || s1_valid || s2_valid;

    // FIFO storage needs no reset: the pointers decide what is live
    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= {in_opcode, in_dst, in_src1, in_src2};
    end

    // FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (issue)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(issue);
        end
    end

    // Register file: a writeback overrides a cfg write to the same index
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            if (cfg_we)
                regs[cfg_addr] <= cfg_data;
            if (s2_valid)
                regs[s2_dst] <= alu_result;
        end
    end

    // Operand registers feeding the ALU; they hold across NOPs and stalls
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            alu_opcode <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
        end else if (issue_alu) begin
            alu_opcode <= head_op;
            alu_op1    <= regs[head_src1];
            alu_op2    <= regs[head_src2];
        end
    end

    // Two-stage in-flight tracker covering issue and the ALU's registered cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_dst   <= '0;
            s2_valid <= 1'b0;
            s2_dst   <= '0;
        end else begin
            s1_valid <= issue_alu;
            if (issue_alu)
                s1_dst <= head_dst;
            s2_valid <= s1_valid;
            s2_dst   <= s1_dst;
        end
    end

    // Sticky status flags captured from each writeback
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else if (s2_valid) begin
            flag_c <= alu_carry;
            flag_z <= alu_zero;
        end
    end
endmodule
